// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage with load-data extraction and a one-entry response buffer.
// Define MS_FWD_EN to drive the decode-stage bypass bus; otherwise ms_fwd_bus is tied to zero.
module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 74,
    parameter int MS_TO_WS_BUS_WD = 70
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    output logic [38:0]                ms_fwd_bus
);

    logic                       ms_valid;
    logic                       ms_ready_go;
    logic [ES_TO_MS_BUS_WD-1:0] payload;
    logic                       buf_valid;
    logic [31:0]                buf_data;
    logic                       buf_capture;

    logic [2:0]  ld_op;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;

    logic [31:0] load_word;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_data;
    logic [31:0] final_result;

    assign {ld_op, res_from_mem, gr_we, dest, alu_result, pc} = payload[73:0];

    assign ms_ready_go    = !res_from_mem || data_sram_data_ok || buf_valid;
    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go;

    // A response only needs parking when WB refuses it in the data_ok cycle.
    assign buf_capture = data_sram_data_ok && ms_valid && res_from_mem && !buf_valid && !ws_allowin;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid <= es_to_ms_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (es_to_ms_valid && ms_allowin) begin
            payload <= es_to_ms_bus;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_valid <= 1'b0;
        end else if (ms_to_ws_valid && ws_allowin) begin
            buf_valid <= 1'b0;
        end else if (buf_capture) begin
            buf_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_capture) begin
            buf_data <= data_sram_rdata;
        end
    end

    always_comb begin
        load_word = buf_valid ? buf_data : data_sram_rdata;
        sel_byte  = load_word[{alu_result[1:0], 3'b000} +: 8];
        sel_half  = alu_result[1] ? load_word[31:16] : load_word[15:0];
        case (ld_op)
            3'b001:  load_data = {{24{sel_byte[7]}}, sel_byte};
            3'b101:  load_data = {24'd0, sel_byte};
            3'b010:  load_data = {{16{sel_half[15]}}, sel_half};
            3'b110:  load_data = {16'd0, sel_half};
            default: load_data = load_word;
        endcase
    end

    assign final_result = res_from_mem ? load_data : alu_result;
    assign ms_to_ws_bus = MS_TO_WS_BUS_WD'({gr_we, dest, final_result, pc});

`ifdef MS_FWD_EN
    assign ms_fwd_bus = ms_valid ? {gr_we, res_from_mem && !ms_ready_go, dest, final_result} : 39'd0;
`else
    assign ms_fwd_bus = 39'd0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against a transaction-level load model.
// Bypass-bus expectations follow MS_FWD_EN the same way the design does.
`timescale 1ns/1ps
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ws_allowin;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [73:0] es_to_ms_bus;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic [38:0] ms_fwd_bus;

    int n_checks = 0;
    int n_fails  = 0;

    logic [2:0]  cur_op;
    logic        cur_load;
    logic        cur_we;
    logic [4:0]  cur_dest;
    logic [31:0] cur_alu;
    logic [31:0] cur_pc;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .ws_allowin        (ws_allowin),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ms_fwd_bus        (ms_fwd_bus)
    );

    // Reference load semantics expressed with shifts, masks and wraparound arithmetic.
    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [1:0] addr, input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * addr)) & 32'hFF;
        h = (w >> (16 * addr[1])) & 32'hFFFF;
        case (op)
            3'd1:    return (b >= 32'd128) ? b - 32'd256 : b;
            3'd5:    return b;
            3'd2:    return (h >= 32'h8000) ? h - 32'h10000 : h;
            3'd6:    return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] cur_result(input logic [31:0] w);
        return cur_load ? ref_load(cur_op, cur_alu[1:0], w) : cur_alu;
    endfunction

    task automatic checkOutput(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkFwd(input string tag, input logic we, input logic pending,
                            input logic [4:0] dst, input logic [31:0] res);
`ifdef MS_FWD_EN
        checkOutput({tag, "_fwd"}, 70'(ms_fwd_bus), 70'({we, pending, dst, res}));
`else
        checkOutput({tag, "_fwd"}, 70'(ms_fwd_bus), 70'({1'b0, 1'b0 & pending & we, 5'd0 & dst, 32'd0 & res}));
`endif
    endtask

    task automatic applyStimulus(input logic v, input logic [73:0] bus, input logic ws,
                                 input logic dok, input logic [31:0] rdata);
        es_to_ms_valid    = v;
        es_to_ms_bus      = bus;
        ws_allowin        = ws;
        data_sram_data_ok = dok;
        data_sram_rdata   = rdata;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_valid"}, 70'(ms_to_ws_valid), 70'd0);
        checkOutput({tag, "_allowin"}, 70'(ms_allowin), 70'd1);
        checkFwd(tag, 1'b0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic checkWaiting(input string tag);
        checkOutput({tag, "_wait_valid"}, 70'(ms_to_ws_valid), 70'd0);
        checkOutput({tag, "_wait_allowin"}, 70'(ms_allowin), 70'd0);
        checkFwd({tag, "_wait"}, cur_we, 1'b1, cur_dest, cur_result(data_sram_rdata));
    endtask

    task automatic checkDeliver(input string tag, input logic [31:0] w);
        checkOutput({tag, "_valid"}, 70'(ms_to_ws_valid), 70'd1);
        checkOutput({tag, "_bus"}, ms_to_ws_bus, {cur_we, cur_dest, cur_result(w), cur_pc});
        checkFwd(tag, cur_we, 1'b0, cur_dest, cur_result(w));
    endtask

    task automatic setCur(input logic [2:0] op, input logic rfm, input logic we,
                          input logic [4:0] dst, input logic [31:0] alu, input logic [31:0] p);
        cur_op   = op;
        cur_load = rfm;
        cur_we   = we;
        cur_dest = dst;
        cur_alu  = alu;
        cur_pc   = p;
    endtask

    task automatic sendInstr(input logic [2:0] op, input logic rfm, input logic we,
                             input logic [4:0] dst, input logic [31:0] alu, input logic [31:0] p);
        checkOutput("allowin_before_send", 70'(ms_allowin), 70'd1);
        setCur(op, rfm, we, dst, alu, p);
        applyStimulus(1'b1, {op, rfm, we, dst, alu, p}, 1'b1, 1'b0, $urandom);
        step();
        applyStimulus(1'b0, $urandom, 1'b1, 1'b0, $urandom);
    endtask

    task automatic doNonLoad(input string tag, input int stall);
        sendInstr(3'($urandom), 1'b0, 1'($urandom), 5'($urandom), $urandom, $urandom);
        applyStimulus(1'b0, es_to_ms_bus, stall == 0, 1'b0, data_sram_rdata);
        checkDeliver(tag, 32'd0);
        for (int i = 0; i < stall; i++) begin
            step();
            checkDeliver({tag, "_held"}, 32'd0);
            checkOutput({tag, "_held_allowin"}, 70'(ms_allowin), 70'd0);
        end
        applyStimulus(1'b0, es_to_ms_bus, 1'b1, 1'b0, data_sram_rdata);
        step();
        checkIdle({tag, "_gone"});
    endtask

    // Stray data_ok pulses are injected on odd stall cycles; the buffered word must survive them.
    task automatic doLoad(input string tag, input logic [2:0] op, input logic [1:0] addr,
                          input logic [31:0] w, input int delay, input int stall);
        sendInstr(op, 1'b1, 1'($urandom), 5'($urandom), {30'($urandom), addr}, $urandom);
        for (int i = 0; i < delay; i++) begin
            checkWaiting(tag);
            step();
        end
        applyStimulus(1'b0, es_to_ms_bus, stall == 0, 1'b1, w);
        checkDeliver({tag, "_dok"}, w);
        for (int i = 0; i < stall; i++) begin
            step();
            applyStimulus(1'b0, es_to_ms_bus, 1'b0, i % 2 == 1, $urandom);
            checkDeliver({tag, "_buf"}, w);
            checkOutput({tag, "_buf_allowin"}, 70'(ms_allowin), 70'd0);
        end
        if (stall > 0) begin
            applyStimulus(1'b0, es_to_ms_bus, 1'b1, 1'b0, $urandom);
            checkDeliver({tag, "_drain"}, w);
            checkOutput({tag, "_drain_allowin"}, 70'(ms_allowin), 70'd1);
        end
        step();
        applyStimulus(1'b0, es_to_ms_bus, 1'b1, 1'b0, $urandom);
        checkIdle({tag, "_gone"});
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 74'd0, 1'b1, 1'b0, 32'd0);
        checkIdle("reset");
        step();
        step();
        checkIdle("reset_held");
        reset = 1'b0;
        #1;
        checkIdle("after_reset");

        // Plain ALU result, one-cycle latency.
        sendInstr(3'd0, 1'b0, 1'b1, 5'd5, 32'h1234_5678, 32'h1C00_0040);
        checkDeliver("nonload", 32'd0);
        step();
        checkIdle("nonload_gone");

        doLoad("ld_b",  3'd1, 2'b11, 32'h80AA_BBCC, 2, 0);
        doLoad("ld_bu", 3'd5, 2'b11, 32'h80AA_BBCC, 2, 0);
        doLoad("ld_hu", 3'd6, 2'b10, 32'hBEEF_0001, 1, 0);
        doLoad("ld_h",  3'd2, 2'b10, 32'hBEEF_0001, 0, 0);
        doLoad("ld_w",  3'd0, 2'b00, 32'h0123_4567, 3, 0);
        doLoad("ld_op7", 3'd7, 2'b01, 32'h89AB_CDEF, 1, 0);

        doLoad("backpressure", 3'd0, 2'b00, 32'hDEAD_BEEF, 0, 3);
        applyStimulus(1'b0, es_to_ms_bus, 1'b1, 1'b1, 32'h1111_1111);
        checkIdle("stray_dok");
        step();
        applyStimulus(1'b0, es_to_ms_bus, 1'b1, 1'b0, 32'd0);
        checkIdle("stray_dok_after");

        // Back-to-back non-loads with the second handshake overlapping the first departure.
        applyStimulus(1'b1, {3'd0, 1'b0, 1'b1, 5'd7, 32'hAAAA_0001, 32'h1C00_0100}, 1'b1, 1'b0, 32'd0);
        step();
        setCur(3'd0, 1'b0, 1'b1, 5'd7, 32'hAAAA_0001, 32'h1C00_0100);
        checkDeliver("b2b_first", 32'd0);
        applyStimulus(1'b1, {3'd0, 1'b0, 1'b0, 5'd9, 32'hBBBB_0002, 32'h1C00_0104}, 1'b1, 1'b0, 32'd0);
        checkOutput("b2b_allowin", 70'(ms_allowin), 70'd1);
        step();
        setCur(3'd0, 1'b0, 1'b0, 5'd9, 32'hBBBB_0002, 32'h1C00_0104);
        checkDeliver("b2b_second", 32'd0);
        applyStimulus(1'b0, es_to_ms_bus, 1'b1, 1'b0, 32'd0);
        step();
        checkIdle("b2b_gone");

        // Reset mid-load must act without a clock edge and drop the late response.
        sendInstr(3'd0, 1'b1, 1'b1, 5'd3, 32'h0000_1000, 32'h1C00_0200);
        checkWaiting("rst_load");
        step();
        checkWaiting("rst_load2");
        reset = 1'b1;
        #1;
        checkIdle("async_reset");
        step();
        reset = 1'b0;
        applyStimulus(1'b0, es_to_ms_bus, 1'b1, 1'b1, 32'hCAFE_F00D);
        checkIdle("late_dok");
        step();
        applyStimulus(1'b0, es_to_ms_bus, 1'b1, 1'b0, 32'd0);
        checkIdle("late_dok_after");

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                doLoad("rand_load", 3'($urandom_range(0, 7)), 2'($urandom), $urandom,
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            end else begin
                doNonLoad("rand_alu", int'($urandom_range(0, 3)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
